forwarding_hazard_unit: RTL and testbench

- Control stage directly upstream of the register-data forwarding muxes in the 5-stage core.
- Keeps its own shadow pipeline of destination-register info for the EXE, MEM and WB stages.
- Each cycle it produces one forwarding select per ID-stage source operand, plus the load-use stall and bubble controls.
- Also counts hazard stall cycles for performance debugging.

---
 rtl/forwarding_hazard_unit.sv | 129 ++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// Forwarding-select and load-use hazard control for the 5-stage core.
// Tracks EXE/MEM/WB destination info in a shadow pipeline and drives operand muxes.

package CorePack;
  typedef enum logic [1:0] {
    FWD_NO  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_enum;
endpackage

// Per-operand hit detection, priority select and load-use flag.
module fhu_operand #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                      id_valid,
  input  logic                      use_rs,
  input  logic [REG_ADDR_W-1:0]     rs,
  input  logic [2:0]                st_v,
  input  logic [2:0]                st_we,
  input  logic [1:0]                st_ld,
  input  logic [2:0][REG_ADDR_W-1:0] st_rd,
  output logic [1:0]                sel,
  output logic                      load_use
);
  import CorePack::*;

  logic [2:0] w_hit;
  logic       w_rs_nz;

  assign w_rs_nz = (rs != '0);

  for (genvar s = 0; s < 3; s++) begin : g_hit
    assign w_hit[s] = st_v[s] & st_we[s] & (st_rd[s] == rs) & w_rs_nz & use_rs & id_valid;
  end

  always_comb begin
    sel = FWD_NO;
    if (w_hit[0] && !st_ld[0])      sel = FWD_EXE;
    else if (w_hit[1] && !st_ld[1]) sel = FWD_MEM;
    else if (w_hit[2])              sel = FWD_WB;
  end

  // The youngest hit decides: a non-load EXE producer masks an older MEM load.
  always_comb begin
    load_use = 1'b0;
    if (w_hit[0])      load_use = st_ld[0];
    else if (w_hit[1]) load_use = st_ld[1];
  end
endmodule

module forwarding_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_we,
  input  logic                  id_is_load,
  input  logic                  mem_stall,
  input  logic                  flush,
  output logic [1:0]            fwd_sel_rs1,
  output logic [1:0]            fwd_sel_rs2,
  output logic                  stall_front,
  output logic                  bubble_exe,
  output logic [CNT_W-1:0]      stall_cycles
);
  // Shadow stage index: 0 = EXE, 1 = MEM, 2 = WB.
  logic [2:0]                  r_v;
  logic [2:0]                  r_we;
  logic [1:0]                  r_ld;
  logic [2:0][REG_ADDR_W-1:0]  r_rd;
  logic [CNT_W-1:0]            r_cnt;

  logic [1:0][REG_ADDR_W-1:0]  w_rs;
  logic [1:0]                  w_use;
  logic [1:0][1:0]             w_sel;
  logic [1:0]                  w_lu;
  logic                        w_load_use;

  assign w_rs  = {id_rs2, id_rs1};
  assign w_use = {id_use_rs2, id_use_rs1};

  for (genvar o = 0; o < 2; o++) begin : g_op
    fhu_operand #(.REG_ADDR_W(REG_ADDR_W)) u_op (
      .id_valid (id_valid),
      .use_rs   (w_use[o]),
      .rs       (w_rs[o]),
      .st_v     (r_v),
      .st_we    (r_we),
      .st_ld    (r_ld),
      .st_rd    (r_rd),
      .sel      (w_sel[o]),
      .load_use (w_lu[o])
    );
  end

  assign w_load_use   = |w_lu;
  assign fwd_sel_rs1  = w_sel[0];
  assign fwd_sel_rs2  = w_sel[1];
  assign stall_front  = w_load_use & ~flush;
  assign bubble_exe   = (w_load_use | flush) & ~mem_stall;
  assign stall_cycles = r_cnt;

  // A stalled or squashed ID instruction enters EXE as an invalid entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v   <= '0;
      r_we  <= '0;
      r_ld  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (!mem_stall) begin
      r_v  <= {r_v[1], r_v[0], id_valid & ~w_load_use & ~flush};
      r_we <= {r_we[1], r_we[0], id_we};
      r_ld <= {r_ld[0], id_is_load};
      r_rd <= {r_rd[1], r_rd[0], id_rd};
      if (w_load_use && !flush && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed vector bench for forwarding_hazard_unit; a second 2-bit-counter
// instance shares all inputs so counter saturation is reachable quickly.
module tb_forwarding_hazard_unit;
  import CorePack::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid, id_use_rs1, id_use_rs2, id_we, id_is_load, mem_stall, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  fwd_sel_rs1, fwd_sel_rs2, s_sel1, s_sel2;
  logic        stall_front, bubble_exe, s_sf, s_bx;
  logic [31:0] stall_cycles;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  forwarding_hazard_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .mem_stall(mem_stall), .flush(flush),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2), .stall_front(stall_front),
    .bubble_exe(bubble_exe), .stall_cycles(stall_cycles)
  );

  forwarding_hazard_unit #(.REG_ADDR_W(5), .CNT_W(2)) u_sat (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .mem_stall(mem_stall), .flush(flush),
    .fwd_sel_rs1(s_sel1), .fwd_sel_rs2(s_sel2), .stall_front(s_sf),
    .bubble_exe(s_bx), .stall_cycles(s_cnt)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we, ld, ms, fl;
    logic [1:0] e1, e2;
    logic       esf, ebx;
    int         ecnt;
  } vec_t;

  vec_t q_main[$];
  vec_t q_sat[$];

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic we, input logic ld, input logic ms, input logic fl,
                              input logic [1:0] e1, input logic [1:0] e2,
                              input logic esf, input logic ebx, input int ecnt);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd;
    t.we = we; t.ld = ld; t.ms = ms; t.fl = fl; t.e1 = e1; t.e2 = e2;
    t.esf = esf; t.ebx = ebx; t.ecnt = ecnt;
    return t;
  endfunction

  function automatic vec_t nop(input int ecnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FWD_NO, FWD_NO, 0, 0, ecnt);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_use_rs1 = t.u1; id_rs2 = t.rs2; id_use_rs2 = t.u2;
    id_rd = t.rd; id_we = t.we; id_is_load = t.ld; mem_stall = t.ms; flush = t.fl;
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    int esat;
    esat = (t.ecnt > 3) ? 3 : t.ecnt;
    apply(t);
    @(negedge clk);
    check({tag, ".sel1"}, 64'(fwd_sel_rs1), 64'(t.e1));
    check({tag, ".sel2"}, 64'(fwd_sel_rs2), 64'(t.e2));
    check({tag, ".stall_front"}, 64'(stall_front), 64'(t.esf));
    check({tag, ".bubble_exe"}, 64'(bubble_exe), 64'(t.ebx));
    check({tag, ".cnt"}, 64'(stall_cycles), 64'(t.ecnt));
    check({tag, ".sat_cnt"}, 64'(s_cnt), 64'(esat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // forwarding from EXE, MEM, WB
    q_main.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, FWD_NO,  FWD_NO, 0, 0, 0));
    q_main.push_back(mk(1, 5, 1, 3, 1, 6, 1, 0, 0, 0, FWD_EXE, FWD_NO, 0, 0, 0));
    q_main.push_back(mk(1, 5, 1, 0, 0, 8, 0, 0, 0, 0, FWD_MEM, FWD_NO, 0, 0, 0));
    q_main.push_back(mk(1, 6, 1, 5, 1, 0, 0, 0, 0, 0, FWD_MEM, FWD_WB, 0, 0, 0));
    q_main.push_back(nop(0));
    // load-use: two stall cycles then WB forward
    q_main.push_back(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, FWD_NO, FWD_NO, 0, 0, 0));
    q_main.push_back(mk(1, 2, 1, 7, 1, 9, 1, 0, 0, 0, FWD_NO, FWD_NO, 1, 1, 0));
    q_main.push_back(mk(1, 2, 1, 7, 1, 9, 1, 0, 0, 0, FWD_NO, FWD_NO, 1, 1, 1));
    q_main.push_back(mk(1, 2, 1, 7, 1, 9, 1, 0, 0, 0, FWD_NO, FWD_WB, 0, 0, 2));
    q_main.push_back(nop(2)); q_main.push_back(nop(2)); q_main.push_back(nop(2));
    // x0 writer, we=0 writer, load to x0
    q_main.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, FWD_NO, FWD_NO, 0, 0, 2));
    q_main.push_back(mk(1, 0, 1, 0, 1, 3, 0, 0, 0, 0, FWD_NO, FWD_NO, 0, 0, 2));
    q_main.push_back(mk(1, 3, 1, 0, 1, 0, 0, 0, 0, 0, FWD_NO, FWD_NO, 0, 0, 2));
    q_main.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, FWD_NO, FWD_NO, 0, 0, 2));
    q_main.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, FWD_NO, FWD_NO, 0, 0, 2));
    q_main.push_back(nop(2)); q_main.push_back(nop(2));
    // load-use held by mem_stall (last frozen cycle also carries flush)
    q_main.push_back(mk(1, 1, 1, 0, 0, 10, 1, 1, 0, 0, FWD_NO, FWD_NO, 0, 0, 2));
    q_main.push_back(mk(1, 10, 1, 0, 0, 11, 1, 0, 0, 0, FWD_NO, FWD_NO, 1, 1, 2));
    q_main.push_back(mk(1, 10, 1, 0, 0, 11, 1, 0, 1, 0, FWD_NO, FWD_NO, 1, 0, 3));
    q_main.push_back(mk(1, 10, 1, 0, 0, 11, 1, 0, 1, 0, FWD_NO, FWD_NO, 1, 0, 3));
    q_main.push_back(mk(1, 10, 1, 0, 0, 11, 1, 0, 1, 1, FWD_NO, FWD_NO, 0, 0, 3));
    q_main.push_back(mk(1, 10, 1, 0, 0, 11, 1, 0, 0, 0, FWD_NO, FWD_NO, 1, 1, 3));
    q_main.push_back(mk(1, 10, 1, 0, 0, 11, 1, 0, 0, 0, FWD_WB, FWD_NO, 0, 0, 4));
    q_main.push_back(nop(4)); q_main.push_back(nop(4)); q_main.push_back(nop(4));
    // flush coincident with load-use squashes the reader
    q_main.push_back(mk(1, 1, 1, 0, 0, 12, 1, 1, 0, 0, FWD_NO, FWD_NO, 0, 0, 4));
    q_main.push_back(mk(1, 12, 1, 0, 0, 13, 1, 0, 0, 1, FWD_NO, FWD_NO, 0, 1, 4));
    q_main.push_back(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, FWD_NO, FWD_NO, 0, 0, 4));
    q_main.push_back(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, FWD_NO, FWD_NO, 0, 0, 4));
    q_main.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, FWD_NO, FWD_NO, 0, 1, 4));
    q_main.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, FWD_NO, FWD_NO, 0, 0, 4));
    q_main.push_back(nop(4));

    // after reset: two load-use stalls drive the 2-bit counter into saturation
    q_sat.push_back(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, FWD_NO, FWD_NO, 0, 0, 0));
    q_sat.push_back(mk(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, FWD_NO, FWD_NO, 1, 1, 0));
    q_sat.push_back(mk(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, FWD_NO, FWD_NO, 1, 1, 1));
    q_sat.push_back(mk(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, FWD_WB, FWD_NO, 0, 0, 2));
    q_sat.push_back(mk(1, 1, 1, 0, 0, 8, 1, 1, 0, 0, FWD_NO, FWD_NO, 0, 0, 2));
    q_sat.push_back(mk(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, FWD_NO, FWD_NO, 1, 1, 2));
    q_sat.push_back(mk(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, FWD_NO, FWD_NO, 1, 1, 3));
    q_sat.push_back(mk(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, FWD_WB, FWD_NO, 0, 0, 4));
    q_sat.push_back(nop(4));

    rstn = 1'b0;
    apply(nop(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.sel1", 64'(fwd_sel_rs1), 64'(FWD_NO));
    check("reset.sel2", 64'(fwd_sel_rs2), 64'(FWD_NO));
    check("reset.stall_front", 64'(stall_front), 0);
    check("reset.bubble_exe", 64'(bubble_exe), 0);
    check("reset.cnt", 64'(stall_cycles), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    foreach (q_main[i]) run_vec(q_main[i], $sformatf("m%0d", i));

    // asynchronous reset in the middle of a load-use stall
    run_vec(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, FWD_NO, FWD_NO, 0, 0, 4), "ar_lw");
    apply(mk(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, FWD_NO, FWD_NO, 1, 1, 4));
    @(negedge clk);
    check("ar.pre_stall", 64'(stall_front), 1);
    rstn = 1'b0;
    #1;
    check("ar.sel1", 64'(fwd_sel_rs1), 64'(FWD_NO));
    check("ar.stall_front", 64'(stall_front), 0);
    check("ar.bubble_exe", 64'(bubble_exe), 0);
    check("ar.cnt", 64'(stall_cycles), 0);
    check("ar.sat_cnt", 64'(s_cnt), 0);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    run_vec(mk(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, FWD_NO, FWD_NO, 0, 0, 0), "ar_after");

    foreach (q_sat[i]) run_vec(q_sat[i], $sformatf("s%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
